// File: rtl/fft_stage2_reorder.sv
// Last radix-2^2 SDF stage of the 16-point FFT: BF1/BF2 butterflies on 4-sample groups,
// round/saturate to the output format, then bit-reversed to natural order via ping-pong banks.
module fft_stage2_reorder #(
  parameter int unsigned N             = 16,
  parameter int unsigned INT_WIDTH_in  = 8,
  parameter int unsigned FRA_WIDTH_in  = 16,
  parameter int unsigned INT_WIDTH_out = 8,
  parameter int unsigned FRA_WIDTH_out = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   di_en,
  input  logic [INT_WIDTH_in+FRA_WIDTH_in-1:0]   di_re,
  input  logic [INT_WIDTH_in+FRA_WIDTH_in-1:0]   di_im,
  output logic                                   do_en,
  output logic [INT_WIDTH_out+FRA_WIDTH_out-1:0] do_re,
  output logic [INT_WIDTH_out+FRA_WIDTH_out-1:0] do_im
);

  localparam int unsigned IW    = INT_WIDTH_in + FRA_WIDTH_in;
  localparam int unsigned OW    = INT_WIDTH_out + FRA_WIDTH_out;
  localparam int unsigned BW    = IW + 2;
  localparam int unsigned Shift = FRA_WIDTH_in - FRA_WIDTH_out;
  localparam int unsigned LogN  = $clog2(N);

  localparam logic        [BW:0] RoundK = {{BW{1'b0}}, 1'b1} << (Shift - 1);
  localparam logic signed [BW:0] OutMax = {{(BW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [BW:0] OutMin = {{(BW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

  typedef logic signed [BW-1:0] bw_t;
  typedef logic        [OW-1:0] ow_t;

  function automatic bw_t sext(input logic [IW-1:0] v);
    return {{2{v[IW-1]}}, v};
  endfunction

  function automatic logic [LogN-1:0] bitrev(input logic [LogN-1:0] a);
    logic [LogN-1:0] r;
    for (int unsigned i = 0; i < LogN; i++) r[i] = a[LogN-1-i];
    return r;
  endfunction

  // Half-up rounding needs one guard bit above the butterfly width before the shift.
  function automatic ow_t round_sat(input bw_t v);
    logic signed [BW:0] s;
    logic signed [BW:0] sh;
    s  = $signed({v[BW-1], v}) + $signed(RoundK);
    sh = s >>> Shift;
    if (sh > OutMax) begin
      return OutMax[OW-1:0];
    end else if (sh < OutMin) begin
      return OutMin[OW-1:0];
    end
    return sh[OW-1:0];
  endfunction

  // Input register and group history
  logic [LogN-1:0] cnt_q;
  logic            in_vld_q;
  logic [LogN-1:0] in_pos_q;
  logic [IW-1:0]   in_re_q;
  logic [IW-1:0]   in_im_q;
  logic [IW-1:0]   hist_re_q [3];
  logic [IW-1:0]   hist_im_q [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      in_vld_q <= 1'b0;
      in_pos_q <= '0;
      in_re_q  <= '0;
      in_im_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        hist_re_q[i] <= '0;
        hist_im_q[i] <= '0;
      end
    end else begin
      in_vld_q <= di_en;
      if (di_en) begin
        cnt_q    <= cnt_q + LogN'(1);
        in_pos_q <= cnt_q;
        in_re_q  <= di_re;
        in_im_q  <= di_im;
      end
      // hist[2] is the oldest sample, i.e. x0 when the current sample is x3
      if (in_vld_q) begin
        hist_re_q[0] <= in_re_q;
        hist_im_q[0] <= in_im_q;
        hist_re_q[1] <= hist_re_q[0];
        hist_im_q[1] <= hist_im_q[0];
        hist_re_q[2] <= hist_re_q[1];
        hist_im_q[2] <= hist_im_q[1];
      end
    end
  end

  // Butterflies for a full group, valid when the current input is x3
  bw_t x_re [4];
  bw_t x_im [4];
  bw_t a0_re, a0_im, a1_re, a1_im, b0_re, b0_im, b1_re, b1_im;
  bw_t bf_re [4];
  bw_t bf_im [4];
  logic grp_done;

  always_comb begin
    x_re[0] = sext(hist_re_q[2]);
    x_im[0] = sext(hist_im_q[2]);
    x_re[1] = sext(hist_re_q[1]);
    x_im[1] = sext(hist_im_q[1]);
    x_re[2] = sext(hist_re_q[0]);
    x_im[2] = sext(hist_im_q[0]);
    x_re[3] = sext(in_re_q);
    x_im[3] = sext(in_im_q);

    a0_re = x_re[0] + x_re[2];
    a0_im = x_im[0] + x_im[2];
    a1_re = x_re[1] + x_re[3];
    a1_im = x_im[1] + x_im[3];
    b0_re = x_re[0] - x_re[2];
    b0_im = x_im[0] - x_im[2];
    b1_re = x_re[1] - x_re[3];
    b1_im = x_im[1] - x_im[3];

    bf_re[0] = a0_re + a1_re;
    bf_im[0] = a0_im + a1_im;
    bf_re[1] = a0_re - a1_re;
    bf_im[1] = a0_im - a1_im;
    // -j*b1 = b1_im - j*b1_re
    bf_re[2] = b0_re + b1_im;
    bf_im[2] = b0_im - b1_re;
    bf_re[3] = b0_re - b1_im;
    bf_im[3] = b0_im + b1_re;

    grp_done = in_vld_q && (in_pos_q[1:0] == 2'd3);
  end

  // Butterfly and conversion pipeline registers
  logic            bf_vld_q, bf_last_q;
  logic [LogN-1:0] bf_pos_q;
  bw_t             bf_re_q [4];
  bw_t             bf_im_q [4];
  logic            cv_vld_q, cv_last_q;
  logic [LogN-1:0] cv_pos_q;
  ow_t             cv_re_q [4];
  ow_t             cv_im_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bf_vld_q  <= 1'b0;
      bf_last_q <= 1'b0;
      bf_pos_q  <= '0;
      cv_vld_q  <= 1'b0;
      cv_last_q <= 1'b0;
      cv_pos_q  <= '0;
      for (int k = 0; k < 4; k++) begin
        bf_re_q[k] <= '0;
        bf_im_q[k] <= '0;
        cv_re_q[k] <= '0;
        cv_im_q[k] <= '0;
      end
    end else begin
      bf_vld_q <= grp_done;
      if (grp_done) begin
        bf_last_q <= (in_pos_q == LogN'(N - 1));
        bf_pos_q  <= in_pos_q & ~LogN'(3);
        for (int k = 0; k < 4; k++) begin
          bf_re_q[k] <= bf_re[k];
          bf_im_q[k] <= bf_im[k];
        end
      end
      cv_vld_q <= bf_vld_q;
      if (bf_vld_q) begin
        cv_last_q <= bf_last_q;
        cv_pos_q  <= bf_pos_q;
        for (int k = 0; k < 4; k++) begin
          cv_re_q[k] <= round_sat(bf_re_q[k]);
          cv_im_q[k] <= round_sat(bf_im_q[k]);
        end
      end
    end
  end

  // Ping-pong reorder banks
  ow_t             bank_re [2][N];
  ow_t             bank_im [2][N];
  logic            wr_bank_q, rd_bank_q, rd_act_q;
  logic [LogN-1:0] rd_cnt_q;
  logic            frame_done;

  assign frame_done = cv_vld_q && cv_last_q;

  always_ff @(posedge clk) begin
    if (cv_vld_q) begin
      for (int k = 0; k < 4; k++) begin
        bank_re[wr_bank_q][bitrev(cv_pos_q | LogN'(k))] <= cv_re_q[k];
        bank_im[wr_bank_q][bitrev(cv_pos_q | LogN'(k))] <= cv_im_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_act_q  <= 1'b0;
      rd_cnt_q  <= '0;
      do_en     <= 1'b0;
      do_re     <= '0;
      do_im     <= '0;
    end else begin
      do_en <= rd_act_q;
      if (rd_act_q) begin
        do_re    <= bank_re[rd_bank_q][rd_cnt_q];
        do_im    <= bank_im[rd_bank_q][rd_cnt_q];
        rd_cnt_q <= rd_cnt_q + LogN'(1);
        if (rd_cnt_q == LogN'(N - 1)) rd_act_q <= 1'b0;
      end else begin
        do_re <= '0;
        do_im <= '0;
      end
      // A freshly filled bank takes over the reader, so back-to-back frames stay contiguous
      if (frame_done) begin
        wr_bank_q <= ~wr_bank_q;
        rd_bank_q <= wr_bank_q;
        rd_act_q  <= 1'b1;
        rd_cnt_q  <= '0;
      end
    end
  end

endmodule
